// File: rtl/axi_ram_slave.sv
`default_nettype none
// ============================================================================
// Module   : axi_ram_slave
// Purpose  : AXI-style burst RAM slave. MEM_DEPTH 32-bit words mapped at
//            BASE_ADDR. It has independent write (AW/W/B) and read (AR/R)
//            engines that support FIXED, INCR and WRAP bursts, byte strobes
//            and per-burst or per-beat error responses.
// Ports    : SLAVE_CLK / SLAVE_RST       clock, synchronous active-high reset
//            SLAVE_WR_ADDR_*            write address channel (ID/ADDR/LEN/BURST)
//            SLAVE_WR_DATA/STRB/LAST    write data channel
//            SLAVE_WR_BACK_*            write response channel (ID/RESP)
//            SLAVE_RD_ADDR_*            read address channel (ID/ADDR/LEN/BURST)
//            SLAVE_RD_BACK_ID, SLAVE_RD_DATA*  read data channel
// Revision : 1.0  initial release
// ============================================================================
module axi_ram_slave #(
    parameter int          MEM_DEPTH = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        SLAVE_CLK,
    input  logic        SLAVE_RST,
    input  logic [1:0]  SLAVE_WR_ADDR_ID,
    input  logic [31:0] SLAVE_WR_ADDR,
    input  logic [7:0]  SLAVE_WR_ADDR_LEN,
    input  logic [1:0]  SLAVE_WR_ADDR_BURST,
    input  logic        SLAVE_WR_ADDR_VALID,
    output logic        SLAVE_WR_ADDR_READY,
    input  logic [31:0] SLAVE_WR_DATA,
    input  logic [3:0]  SLAVE_WR_STRB,
    input  logic        SLAVE_WR_DATA_LAST,
    input  logic        SLAVE_WR_DATA_VALID,
    output logic        SLAVE_WR_DATA_READY,
    output logic [1:0]  SLAVE_WR_BACK_ID,
    output logic [1:0]  SLAVE_WR_BACK_RESP,
    output logic        SLAVE_WR_BACK_VALID,
    input  logic        SLAVE_WR_BACK_READY,
    input  logic [1:0]  SLAVE_RD_ADDR_ID,
    input  logic [31:0] SLAVE_RD_ADDR,
    input  logic [7:0]  SLAVE_RD_ADDR_LEN,
    input  logic [1:0]  SLAVE_RD_ADDR_BURST,
    input  logic        SLAVE_RD_ADDR_VALID,
    output logic        SLAVE_RD_ADDR_READY,
    output logic [1:0]  SLAVE_RD_BACK_ID,
    output logic [31:0] SLAVE_RD_DATA,
    output logic [1:0]  SLAVE_RD_DATA_RESP,
    output logic        SLAVE_RD_DATA_LAST,
    output logic        SLAVE_RD_DATA_VALID,
    input  logic        SLAVE_RD_DATA_READY
);

    localparam int c_IDX_W = $clog2(MEM_DEPTH);
    localparam logic [31-c_IDX_W-2:0] c_BASE_TAG = BASE_ADDR[31:c_IDX_W+2];

    localparam logic [1:0] c_FIXED  = 2'b00;
    localparam logic [1:0] c_WRAP   = 2'b10;
    localparam logic [1:0] c_OKAY   = 2'b00;
    localparam logic [1:0] c_SLVERR = 2'b10;
    localparam logic [1:0] c_DECERR = 2'b11;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    // Only lengths of 2, 4, 8 or 16 beats form a legal wrap window.
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

    // Address of the beat after 'a'. An illegal WRAP burst advances like INCR.
    function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [7:0] len,
                                              input logic [1:0] burst, input logic bad_wrap);
        logic [31:0] inc;
        logic [31:0] mask;
        inc  = a + 32'd4;
        mask = {22'd0, len, 2'b11};
        if (burst == c_FIXED)
            return a;
        else if ((burst == c_WRAP) && !bad_wrap)
            return (a & ~mask) | (inc & mask);
        else
            return inc;
    endfunction

    logic [31:0] r_mem [MEM_DEPTH];

    // Holds READY outputs low for the first cycle after reset is released.
    logic        r_out_en;

    // ---------------- write engine ----------------
    logic [1:0]  r_w_state;
    logic [1:0]  w_w_state_nxt;
    logic [1:0]  r_w_id;
    logic [31:0] r_w_addr;
    logic [7:0]  r_w_len;
    logic [1:0]  r_w_burst;
    logic        r_w_bad_wrap;
    logic [7:0]  r_w_cnt;
    logic        r_w_slverr;
    logic        r_w_decerr;

    logic        w_aw_hs;
    logic        w_w_hs;
    logic        w_w_final;
    logic        w_w_in_range;
    logic        w_mem_we;
    logic [c_IDX_W-1:0] w_w_idx;

    assign w_aw_hs      = SLAVE_WR_ADDR_VALID && SLAVE_WR_ADDR_READY;
    assign w_w_hs       = SLAVE_WR_DATA_VALID && SLAVE_WR_DATA_READY;
    assign w_w_final    = (r_w_cnt == r_w_len);
    assign w_w_in_range = (r_w_addr[31:c_IDX_W+2] == c_BASE_TAG);
    assign w_w_idx      = r_w_addr[c_IDX_W+1:2];
    // A beat that coincides with a reset edge is dropped along with the burst.
    assign w_mem_we     = w_w_hs && w_w_in_range && !SLAVE_RST;

    always_ff @(posedge SLAVE_CLK) begin
        if (SLAVE_RST) r_w_state <= W_IDLE;
        else           r_w_state <= w_w_state_nxt;
    end

    always_comb begin
        w_w_state_nxt = r_w_state;
        case (r_w_state)
            W_IDLE:  if (w_aw_hs) w_w_state_nxt = W_DATA;
            W_DATA:  if (w_w_hs && w_w_final) w_w_state_nxt = W_RESP;
            W_RESP:  if (SLAVE_WR_BACK_READY) w_w_state_nxt = W_IDLE;
            default: w_w_state_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        SLAVE_WR_ADDR_READY = r_out_en && (r_w_state == W_IDLE);
        SLAVE_WR_DATA_READY = r_out_en && (r_w_state == W_DATA);
        SLAVE_WR_BACK_VALID = (r_w_state == W_RESP);
        SLAVE_WR_BACK_ID    = r_w_id;
        if (r_w_decerr)      SLAVE_WR_BACK_RESP = c_DECERR;
        else if (r_w_slverr) SLAVE_WR_BACK_RESP = c_SLVERR;
        else                 SLAVE_WR_BACK_RESP = c_OKAY;
    end

    always_ff @(posedge SLAVE_CLK) begin
        if (SLAVE_RST) begin
            r_out_en     <= 1'b0;
            r_w_id       <= 2'd0;
            r_w_addr     <= 32'd0;
            r_w_len      <= 8'd0;
            r_w_burst    <= 2'd0;
            r_w_bad_wrap <= 1'b0;
            r_w_cnt      <= 8'd0;
            r_w_slverr   <= 1'b0;
            r_w_decerr   <= 1'b0;
        end else begin
            r_out_en <= 1'b1;
            if (w_aw_hs) begin
                r_w_id       <= SLAVE_WR_ADDR_ID;
                r_w_addr     <= SLAVE_WR_ADDR;
                r_w_len      <= SLAVE_WR_ADDR_LEN;
                r_w_burst    <= SLAVE_WR_ADDR_BURST;
                r_w_bad_wrap <= (SLAVE_WR_ADDR_BURST == c_WRAP) && !wrap_len_ok(SLAVE_WR_ADDR_LEN);
                r_w_slverr   <= (SLAVE_WR_ADDR_BURST == c_WRAP) && !wrap_len_ok(SLAVE_WR_ADDR_LEN);
                r_w_cnt      <= 8'd0;
                r_w_decerr   <= 1'b0;
            end
            if (w_w_hs) begin
                r_w_addr <= next_addr(r_w_addr, r_w_len, r_w_burst, r_w_bad_wrap);
                r_w_cnt  <= r_w_cnt + 8'd1;
                // LAST must be high exactly on the final beat; either error keeps the beat count.
                if (SLAVE_WR_DATA_LAST != w_w_final) r_w_slverr <= 1'b1;
                if (!w_w_in_range)                   r_w_decerr <= 1'b1;
            end
        end
    end

    // Storage is deliberately outside reset so contents survive it.
    always_ff @(posedge SLAVE_CLK) begin
        if (w_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (SLAVE_WR_STRB[b]) r_mem[w_w_idx][8*b +: 8] <= SLAVE_WR_DATA[8*b +: 8];
            end
        end
    end

    // ---------------- read engine ----------------
    logic [0:0]  r_r_state;
    logic [0:0]  w_r_state_nxt;
    logic [1:0]  r_r_id;
    logic [31:0] r_r_addr;
    logic [7:0]  r_r_len;
    logic [1:0]  r_r_burst;
    logic        r_r_bad_wrap;
    logic [7:0]  r_r_cnt;
    logic        r_r_valid;
    logic [31:0] r_r_data;
    logic [1:0]  r_r_resp;
    logic        r_r_last;

    logic        w_ar_hs;
    logic        w_r_hs;
    logic        w_r_load;
    logic        w_r_in_range;
    logic [c_IDX_W-1:0] w_r_idx;

    assign w_ar_hs      = SLAVE_RD_ADDR_VALID && SLAVE_RD_ADDR_READY;
    assign w_r_hs       = r_r_valid && SLAVE_RD_DATA_READY;
    assign w_r_in_range = (r_r_addr[31:c_IDX_W+2] == c_BASE_TAG);
    assign w_r_idx      = r_r_addr[c_IDX_W+1:2];
    // Fetch the next beat into the output register whenever it is empty or
    // being drained this cycle, so an always-ready master sees one beat per cycle.
    assign w_r_load     = (r_r_state == R_DATA) && (!r_r_valid || (SLAVE_RD_DATA_READY && !r_r_last));

    always_ff @(posedge SLAVE_CLK) begin
        if (SLAVE_RST) r_r_state <= R_IDLE;
        else           r_r_state <= w_r_state_nxt;
    end

    always_comb begin
        w_r_state_nxt = r_r_state;
        case (r_r_state)
            R_IDLE:  if (w_ar_hs) w_r_state_nxt = R_DATA;
            R_DATA:  if (w_r_hs && r_r_last) w_r_state_nxt = R_IDLE;
            default: w_r_state_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        SLAVE_RD_ADDR_READY = r_out_en && (r_r_state == R_IDLE);
        SLAVE_RD_DATA_VALID = r_r_valid;
        SLAVE_RD_DATA       = r_r_data;
        SLAVE_RD_DATA_RESP  = r_r_resp;
        SLAVE_RD_DATA_LAST  = r_r_last;
        SLAVE_RD_BACK_ID    = r_r_id;
    end

    always_ff @(posedge SLAVE_CLK) begin
        if (SLAVE_RST) begin
            r_r_id       <= 2'd0;
            r_r_addr     <= 32'd0;
            r_r_len      <= 8'd0;
            r_r_burst    <= 2'd0;
            r_r_bad_wrap <= 1'b0;
            r_r_cnt      <= 8'd0;
            r_r_valid    <= 1'b0;
            r_r_data     <= 32'd0;
            r_r_resp     <= 2'd0;
            r_r_last     <= 1'b0;
        end else begin
            if (w_ar_hs) begin
                r_r_id       <= SLAVE_RD_ADDR_ID;
                r_r_addr     <= SLAVE_RD_ADDR;
                r_r_len      <= SLAVE_RD_ADDR_LEN;
                r_r_burst    <= SLAVE_RD_ADDR_BURST;
                r_r_bad_wrap <= (SLAVE_RD_ADDR_BURST == c_WRAP) && !wrap_len_ok(SLAVE_RD_ADDR_LEN);
                r_r_cnt      <= 8'd0;
            end
            if (w_r_load) begin
                r_r_data  <= w_r_in_range ? r_mem[w_r_idx] : 32'd0;
                if (!w_r_in_range)    r_r_resp <= c_DECERR;
                else if (r_r_bad_wrap) r_r_resp <= c_SLVERR;
                else                   r_r_resp <= c_OKAY;
                r_r_last  <= (r_r_cnt == r_r_len);
                r_r_cnt   <= r_r_cnt + 8'd1;
                r_r_addr  <= next_addr(r_r_addr, r_r_len, r_r_burst, r_r_bad_wrap);
                r_r_valid <= 1'b1;
            end else if (w_r_hs) begin
                // Only the final beat is accepted without a refill.
                r_r_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_ram_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_ram_slave
// Purpose  : Directed self-checking bench for axi_ram_slave (MEM_DEPTH=256,
//            BASE_ADDR=0). Expected values are hand-computed constants.
// Revision : 1.0  initial release
// ============================================================================
module tb_axi_ram_slave;

    localparam logic [1:0] c_FIXED = 2'b00;
    localparam logic [1:0] c_INCR  = 2'b01;
    localparam logic [1:0] c_WRAP  = 2'b10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  r_aw_id;
    logic [31:0] r_aw_addr;
    logic [7:0]  r_aw_len;
    logic [1:0]  r_aw_burst;
    logic        r_aw_valid;
    logic        w_aw_ready;
    logic [31:0] r_w_data;
    logic [3:0]  r_w_strb;
    logic        r_w_last;
    logic        r_w_valid;
    logic        w_w_ready;
    logic [1:0]  w_b_id;
    logic [1:0]  w_b_resp;
    logic        w_b_valid;
    logic        r_b_ready;
    logic [1:0]  r_ar_id;
    logic [31:0] r_ar_addr;
    logic [7:0]  r_ar_len;
    logic [1:0]  r_ar_burst;
    logic        r_ar_valid;
    logic        w_ar_ready;
    logic [1:0]  w_r_id;
    logic [31:0] w_r_data;
    logic [1:0]  w_r_resp;
    logic        w_r_last;
    logic        w_r_valid;
    logic        r_r_ready;

    axi_ram_slave dut (
        .SLAVE_CLK           (clk),
        .SLAVE_RST           (rst),
        .SLAVE_WR_ADDR_ID    (r_aw_id),
        .SLAVE_WR_ADDR       (r_aw_addr),
        .SLAVE_WR_ADDR_LEN   (r_aw_len),
        .SLAVE_WR_ADDR_BURST (r_aw_burst),
        .SLAVE_WR_ADDR_VALID (r_aw_valid),
        .SLAVE_WR_ADDR_READY (w_aw_ready),
        .SLAVE_WR_DATA       (r_w_data),
        .SLAVE_WR_STRB       (r_w_strb),
        .SLAVE_WR_DATA_LAST  (r_w_last),
        .SLAVE_WR_DATA_VALID (r_w_valid),
        .SLAVE_WR_DATA_READY (w_w_ready),
        .SLAVE_WR_BACK_ID    (w_b_id),
        .SLAVE_WR_BACK_RESP  (w_b_resp),
        .SLAVE_WR_BACK_VALID (w_b_valid),
        .SLAVE_WR_BACK_READY (r_b_ready),
        .SLAVE_RD_ADDR_ID    (r_ar_id),
        .SLAVE_RD_ADDR       (r_ar_addr),
        .SLAVE_RD_ADDR_LEN   (r_ar_len),
        .SLAVE_RD_ADDR_BURST (r_ar_burst),
        .SLAVE_RD_ADDR_VALID (r_ar_valid),
        .SLAVE_RD_ADDR_READY (w_ar_ready),
        .SLAVE_RD_BACK_ID    (w_r_id),
        .SLAVE_RD_DATA       (w_r_data),
        .SLAVE_RD_DATA_RESP  (w_r_resp),
        .SLAVE_RD_DATA_LAST  (w_r_last),
        .SLAVE_RD_DATA_VALID (w_r_valid),
        .SLAVE_RD_DATA_READY (r_r_ready)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] wbeat [16];
    logic [31:0] exp_d [16];
    logic [31:0] rd_data [16];
    logic [1:0]  rd_resp [16];
    logic        rd_last [16];
    logic [1:0]  rd_id [16];
    int          rd_n;
    logic [1:0]  b_id;
    logic [1:0]  b_resp;

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic write_burst(input logic [1:0] id, input logic [31:0] addr, input logic [7:0] len,
                               input logic [1:0] burst, input logic [3:0] strb, input int last_at,
                               input int b_hold, output logic [1:0] bid, output logic [1:0] bresp);
        int t;
        r_aw_id = id; r_aw_addr = addr; r_aw_len = len; r_aw_burst = burst; r_aw_valid = 1'b1;
        t = 0;
        while (!w_aw_ready && t < 100) begin @(posedge clk); #1; t++; end
        if (!w_aw_ready) check_value("aw_wait", w_aw_ready, 1);
        @(posedge clk); #1;
        r_aw_valid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            r_w_data = wbeat[i]; r_w_strb = strb; r_w_last = (i == last_at); r_w_valid = 1'b1;
            t = 0;
            while (!w_w_ready && t < 100) begin @(posedge clk); #1; t++; end
            if (!w_w_ready) check_value("w_wait", w_w_ready, 1);
            @(posedge clk); #1;
        end
        r_w_valid = 1'b0; r_w_last = 1'b0;
        t = 0;
        while (!w_b_valid && t < 100) begin @(posedge clk); #1; t++; end
        if (!w_b_valid) check_value("b_wait", w_b_valid, 1);
        bid = w_b_id; bresp = w_b_resp;
        for (int k = 0; k < b_hold; k++) begin
            @(posedge clk); #1;
            check_value("b_hold", {w_b_valid, w_b_id, w_b_resp}, {1'b1, bid, bresp});
        end
        r_b_ready = 1'b1;
        @(posedge clk); #1;
        r_b_ready = 1'b0;
        check_value("b_done", w_b_valid, 0);
    endtask

    task automatic read_burst(input logic [1:0] id, input logic [31:0] addr, input logic [7:0] len,
                              input logic [1:0] burst, input bit rnd);
        int t;
        bit stalled;
        logic [36:0] held;
        r_ar_id = id; r_ar_addr = addr; r_ar_len = len; r_ar_burst = burst; r_ar_valid = 1'b1;
        t = 0;
        while (!w_ar_ready && t < 100) begin @(posedge clk); #1; t++; end
        if (!w_ar_ready) check_value("ar_wait", w_ar_ready, 1);
        @(posedge clk); #1;
        r_ar_valid = 1'b0;
        check_value("r_lat_early", w_r_valid, 0);
        @(posedge clk); #1;
        check_value("r_lat_first", w_r_valid, 1);
        rd_n = 0; t = 0; stalled = 1'b0; held = '0;
        while (rd_n <= int'(len) && t < 1000) begin
            if (stalled) check_value("r_stall_hold", {w_r_id, w_r_resp, w_r_last, w_r_data}, held);
            r_r_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            stalled = 1'b0;
            if (w_r_valid && r_r_ready) begin
                rd_id[rd_n] = w_r_id; rd_resp[rd_n] = w_r_resp;
                rd_last[rd_n] = w_r_last; rd_data[rd_n] = w_r_data;
                rd_n++;
            end else if (w_r_valid) begin
                stalled = 1'b1;
                held = {w_r_id, w_r_resp, w_r_last, w_r_data};
            end
            @(posedge clk); #1; t++;
        end
        r_r_ready = 1'b0;
        check_value("r_no_extra", w_r_valid, 0);
    endtask

    task automatic check_reads(input string tag, input int len, input logic [1:0] id, input logic [1:0] resp);
        check_value($sformatf("%s_beats", tag), rd_n, len + 1);
        for (int i = 0; i <= len && i < rd_n; i++) begin
            check_value($sformatf("%s[%0d]", tag, i),
                        {rd_id[i], rd_resp[i], rd_last[i], rd_data[i]},
                        {id, resp, 1'(i == len), exp_d[i]});
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_value({tag, "_ctl"},
                    {w_aw_ready, w_w_ready, w_b_valid, w_b_id, w_b_resp, w_ar_ready, w_r_valid, w_r_last, w_r_id, w_r_resp},
                    14'd0);
        check_value({tag, "_rdata"}, w_r_data, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        r_aw_id = 0; r_aw_addr = 0; r_aw_len = 0; r_aw_burst = 0; r_aw_valid = 0;
        r_w_data = 0; r_w_strb = 0; r_w_last = 0; r_w_valid = 0; r_b_ready = 0;
        r_ar_id = 0; r_ar_addr = 0; r_ar_len = 0; r_ar_burst = 0; r_ar_valid = 0; r_r_ready = 0;

        // Reset state and READY release timing
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;
        check_value("ready_rise", {w_aw_ready, w_w_ready, w_ar_ready}, 3'b101);

        // INCR write then read back
        for (int i = 0; i < 4; i++) wbeat[i] = 32'hA0 + i;
        write_burst(2'd1, 32'h10, 8'd3, c_INCR, 4'hF, 3, 0, b_id, b_resp);
        check_value("incr_bresp", {b_id, b_resp}, {2'd1, 2'b00});
        read_burst(2'd2, 32'h10, 8'd3, c_INCR, 1'b0);
        for (int i = 0; i < 4; i++) exp_d[i] = 32'hA0 + i;
        check_reads("incr_rd", 3, 2'd2, 2'b00);

        // Byte strobes
        wbeat[0] = 32'h1122_3344;
        write_burst(2'd0, 32'h0, 8'd0, c_INCR, 4'hF, 0, 0, b_id, b_resp);
        check_value("strb_b1", {b_id, b_resp}, {2'd0, 2'b00});
        wbeat[0] = 32'hAABB_CCDD;
        write_burst(2'd0, 32'h0, 8'd0, c_INCR, 4'h5, 0, 0, b_id, b_resp);
        check_value("strb_b2", {b_id, b_resp}, {2'd0, 2'b00});
        read_burst(2'd0, 32'h0, 8'd0, c_INCR, 1'b0);
        exp_d[0] = 32'h11BB_33DD;
        check_reads("strb_rd", 0, 2'd0, 2'b00);

        // WRAP legal and illegal length
        for (int i = 0; i < 4; i++) wbeat[i] = i;
        write_burst(2'd0, 32'h0, 8'd3, c_INCR, 4'hF, 3, 0, b_id, b_resp);
        check_value("wrap_setup_b", {b_id, b_resp}, {2'd0, 2'b00});
        read_burst(2'd1, 32'h08, 8'd3, c_WRAP, 1'b0);
        exp_d[0] = 2; exp_d[1] = 3; exp_d[2] = 0; exp_d[3] = 1;
        check_reads("wrap_rd", 3, 2'd1, 2'b00);
        read_burst(2'd1, 32'h00, 8'd2, c_WRAP, 1'b0);
        exp_d[0] = 0; exp_d[1] = 1; exp_d[2] = 2;
        check_reads("wrap_bad_rd", 2, 2'd1, 2'b10);

        // FIXED burst: every beat hits the same word
        wbeat[0] = 32'h5; wbeat[1] = 32'h6; wbeat[2] = 32'h7;
        write_burst(2'd2, 32'h20, 8'd2, c_FIXED, 4'hF, 2, 0, b_id, b_resp);
        check_value("fixed_b", {b_id, b_resp}, {2'd2, 2'b00});
        read_burst(2'd2, 32'h20, 8'd1, c_FIXED, 1'b0);
        exp_d[0] = 32'h7; exp_d[1] = 32'h7;
        check_reads("fixed_rd", 1, 2'd2, 2'b00);

        // Out of range write/read, memory not aliased
        wbeat[0] = 32'hDEAD_BEEF;
        write_burst(2'd3, 32'h400, 8'd0, c_INCR, 4'hF, 0, 0, b_id, b_resp);
        check_value("oor_b", {b_id, b_resp}, {2'd3, 2'b11});
        read_burst(2'd0, 32'h0, 8'd0, c_INCR, 1'b0);
        exp_d[0] = 32'h0;
        check_reads("oor_alias_rd", 0, 2'd0, 2'b00);
        read_burst(2'd0, 32'h400, 8'd0, c_INCR, 1'b0);
        exp_d[0] = 32'h0;
        check_reads("oor_rd", 0, 2'd0, 2'b11);

        // WLAST errors: early on beat 0, and never asserted
        wbeat[0] = 32'h55; wbeat[1] = 32'h66;
        write_burst(2'd1, 32'h30, 8'd1, c_INCR, 4'hF, 0, 0, b_id, b_resp);
        check_value("early_last_b", {b_id, b_resp}, {2'd1, 2'b10});
        write_burst(2'd1, 32'h38, 8'd1, c_INCR, 4'hF, -1, 0, b_id, b_resp);
        check_value("no_last_b", {b_id, b_resp}, {2'd1, 2'b10});
        read_burst(2'd0, 32'h30, 8'd3, c_INCR, 1'b0);
        exp_d[0] = 32'h55; exp_d[1] = 32'h66; exp_d[2] = 32'h55; exp_d[3] = 32'h66;
        check_reads("last_err_rd", 3, 2'd0, 2'b00);

        // Illegal WRAP write behaves as INCR with SLVERR
        wbeat[0] = 32'h77; wbeat[1] = 32'h88; wbeat[2] = 32'h99;
        write_burst(2'd2, 32'h40, 8'd2, c_WRAP, 4'hF, 2, 0, b_id, b_resp);
        check_value("wrap_bad_b", {b_id, b_resp}, {2'd2, 2'b10});
        read_burst(2'd0, 32'h40, 8'd2, c_INCR, 1'b0);
        exp_d[0] = 32'h77; exp_d[1] = 32'h88; exp_d[2] = 32'h99;
        check_reads("wrap_bad_wr_rd", 2, 2'd0, 2'b00);

        // Back-pressure: BREADY held low, RREADY random
        for (int i = 0; i < 4; i++) wbeat[i] = 32'h1000 + i;
        write_burst(2'd2, 32'h50, 8'd3, c_INCR, 4'hF, 3, 10, b_id, b_resp);
        check_value("stall_b", {b_id, b_resp}, {2'd2, 2'b00});
        read_burst(2'd1, 32'h50, 8'd3, c_INCR, 1'b1);
        for (int i = 0; i < 4; i++) exp_d[i] = 32'h1000 + i;
        check_reads("stall_rd", 3, 2'd1, 2'b00);

        // Concurrent write and read on different words
        for (int i = 0; i < 8; i++) wbeat[i] = 32'h200 + i;
        fork
            write_burst(2'd3, 32'h80, 8'd7, c_INCR, 4'hF, 7, 0, b_id, b_resp);
            read_burst(2'd1, 32'h10, 8'd3, c_INCR, 1'b1);
        join
        check_value("conc_b", {b_id, b_resp}, {2'd3, 2'b00});
        for (int i = 0; i < 4; i++) exp_d[i] = 32'hA0 + i;
        check_reads("conc_rd", 3, 2'd1, 2'b00);
        read_burst(2'd3, 32'h80, 8'd7, c_INCR, 1'b0);
        for (int i = 0; i < 8; i++) exp_d[i] = 32'h200 + i;
        check_reads("conc_wr_rd", 7, 2'd3, 2'b00);

        // Reset during beat 2 of a len-7 write
        for (int i = 0; i < 8; i++) wbeat[i] = 32'h300 + i;
        r_aw_id = 2'd2; r_aw_addr = 32'h100; r_aw_len = 8'd7; r_aw_burst = c_INCR; r_aw_valid = 1'b1;
        @(posedge clk); #1;
        r_aw_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            r_w_data = wbeat[i]; r_w_strb = 4'hF; r_w_last = 1'b0; r_w_valid = 1'b1;
            @(posedge clk); #1;
        end
        r_w_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("midrst");
        rst = 1'b0;
        @(posedge clk); #1;
        check_value("midrst_ready", {w_aw_ready, w_w_ready, w_ar_ready}, 3'b101);
        read_burst(2'd0, 32'h100, 8'd1, c_INCR, 1'b0);
        exp_d[0] = 32'h300; exp_d[1] = 32'h301;
        check_reads("midrst_kept", 1, 2'd0, 2'b00);
        wbeat[0] = 32'h400; wbeat[1] = 32'h401;
        write_burst(2'd1, 32'h140, 8'd1, c_INCR, 4'hF, 1, 0, b_id, b_resp);
        check_value("post_rst_b", {b_id, b_resp}, {2'd1, 2'b00});
        read_burst(2'd1, 32'h140, 8'd1, c_INCR, 1'b0);
        exp_d[0] = 32'h400; exp_d[1] = 32'h401;
        check_reads("post_rst_rd", 1, 2'd1, 2'b00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
